// File: rtl/pl_hazard_unit_pkg.sv
// Shared types for the pipeline hazard unit: register address width,
// forwarding-select encodings, load marker and the scoreboard entry layout.
package pl_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwdSel_e;

    localparam logic [1:0] RES_LOAD = 2'b01;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regWrite;
        logic                  isLoad;
    } sbEntry_t;

    // An entry produces a value for src when it writes a non-x0 register equal to src.
    function automatic logic writesReg(sbEntry_t e, logic [REG_ADDR_W-1:0] src);
        return e.regWrite && (e.rd != '0) && (e.rd == src);
    endfunction

endpackage

// File: rtl/hz_scoreboard.sv
// Three-deep E/M/W shadow of the pipeline's register usage; a flush of E
// inserts an all-zero bubble in place of the decode fields.
module hz_scoreboard
    import pl_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     flushE,
    input  sbEntry_t entryD,
    output sbEntry_t entryE,
    output sbEntry_t entryM,
    output sbEntry_t entryW
);

    always_ff @(posedge clk) begin
        if (reset) begin
            entryE <= '0;
            entryM <= '0;
            entryW <= '0;
        end else begin
            entryE <= flushE ? '0 : entryD;
            entryM <= entryE;
            entryW <= entryM;
        end
    end

endmodule

// File: rtl/pl_hazard_unit.sv
// Hazard detection, operand forwarding and stall/flush performance counters
// for a 5-stage pipeline; outputs are combinational from scoreboard + decode.
module pl_hazard_unit
    import pl_pkg::*;
#(
    parameter int FWD_EN   = 1,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] RdD,
    input  logic                  RegWriteD,
    input  logic [1:0]            ResultSrcD,
    input  logic                  PCSrcE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic [CNT_W-1:0]      StallCnt,
    output logic [CNT_W-1:0]      FlushCnt
);

    localparam logic [1:0] LAT_M1 = 2'(LOAD_LAT - 1);

    sbEntry_t   entryD, entryE, entryM, entryW;
    logic [1:0] stallCtr, stallCtrNext;
    logic       matchE, matchM, loadUse, hazStall;
    fwdSel_e    fwdA, fwdB;

    assign entryD = '{rs1: Rs1D, rs2: Rs2D, rd: RdD, regWrite: RegWriteD,
                      isLoad: (ResultSrcD == RES_LOAD)};

    hz_scoreboard uScoreboard (
        .clk   (clk),
        .reset (reset),
        .flushE(FlushE),
        .entryD(entryD),
        .entryE(entryE),
        .entryM(entryM),
        .entryW(entryW)
    );

    always_comb begin
        fwdA = FWD_RF;
        fwdB = FWD_RF;
        if (FWD_EN != 0) begin
            if (writesReg(entryM, entryE.rs1))      fwdA = FWD_M;
            else if (writesReg(entryW, entryE.rs1)) fwdA = FWD_W;
            if (writesReg(entryM, entryE.rs2))      fwdB = FWD_M;
            else if (writesReg(entryW, entryE.rs2)) fwdB = FWD_W;
        end
    end

    assign ForwardAE = fwdA;
    assign ForwardBE = fwdB;

    always_comb begin
        matchE   = writesReg(entryE, Rs1D) || writesReg(entryE, Rs2D);
        matchM   = writesReg(entryM, Rs1D) || writesReg(entryM, Rs2D);
        loadUse  = 1'b0;
        hazStall = 1'b0;
        if (FWD_EN != 0) begin
            loadUse  = matchE && entryE.isLoad;
            hazStall = loadUse || (stallCtr != '0);
        end else begin
            // Write-through register file: a W producer is already visible to D.
            hazStall = matchE || matchM;
        end

        stallCtrNext = '0;
        if (PCSrcE)               stallCtrNext = '0;
        else if (stallCtr != '0)  stallCtrNext = stallCtr - 2'd1;
        else if (loadUse)         stallCtrNext = LAT_M1;
    end

    // A redirect wins over any stall in the same cycle.
    assign StallF = hazStall && !PCSrcE;
    assign StallD = hazStall && !PCSrcE;
    assign FlushD = PCSrcE;
    assign FlushE = hazStall || PCSrcE;

    always_ff @(posedge clk) begin
        if (reset) begin
            stallCtr <= '0;
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            stallCtr <= stallCtrNext;
            if (StallD) StallCnt <= StallCnt + CNT_W'(1);
            if (PCSrcE) FlushCnt <= FlushCnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pl_hazard_unit.sv
// Table-driven bench: instance A forwards (LOAD_LAT=2), instance B is
// stall-only with 4-bit counters to exercise wrap-around.
module tb_pl_hazard_unit;
    import pl_pkg::*;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rw;
        logic [1:0] rsrc;
        logic       pc;
        logic       rst;
        logic [7:0] exp;  // {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE}
    } vec_t;

    localparam logic [7:0] Z  = 8'b0000_0000;
    localparam logic [7:0] ST = 8'b1101_0000;
    localparam logic [7:0] BR = 8'b0011_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [4:0]  aRs1 = '0, aRs2 = '0, aRd = '0;
    logic        aRw = 1'b0, aPc = 1'b0, aRst = 1'b1;
    logic [1:0]  aRes = '0;
    logic        aStallF, aStallD, aFlushD, aFlushE;
    logic [1:0]  aFwdA, aFwdB;
    logic [31:0] aStallCnt, aFlushCnt;

    logic [4:0]  bRs1 = '0, bRs2 = '0, bRd = '0;
    logic        bRw = 1'b0, bPc = 1'b0, bRst = 1'b1;
    logic [1:0]  bRes = '0;
    logic        bStallF, bStallD, bFlushD, bFlushE;
    logic [1:0]  bFwdA, bFwdB;
    logic [3:0]  bStallCnt, bFlushCnt;

    pl_hazard_unit #(.FWD_EN(1), .LOAD_LAT(2), .CNT_W(32)) dutA (
        .clk(clk), .reset(aRst), .Rs1D(aRs1), .Rs2D(aRs2), .RdD(aRd),
        .RegWriteD(aRw), .ResultSrcD(aRes), .PCSrcE(aPc),
        .StallF(aStallF), .StallD(aStallD), .FlushD(aFlushD), .FlushE(aFlushE),
        .ForwardAE(aFwdA), .ForwardBE(aFwdB),
        .StallCnt(aStallCnt), .FlushCnt(aFlushCnt)
    );

    pl_hazard_unit #(.FWD_EN(0), .LOAD_LAT(1), .CNT_W(4)) dutB (
        .clk(clk), .reset(bRst), .Rs1D(bRs1), .Rs2D(bRs2), .RdD(bRd),
        .RegWriteD(bRw), .ResultSrcD(bRes), .PCSrcE(bPc),
        .StallF(bStallF), .StallD(bStallD), .FlushD(bFlushD), .FlushE(bFlushE),
        .ForwardAE(bFwdA), .ForwardBE(bFwdB),
        .StallCnt(bStallCnt), .FlushCnt(bFlushCnt)
    );

    int unsigned tests = 0;
    int unsigned fails = 0;
    logic [7:0]  expQ[$];
    vec_t        tabA[31];
    vec_t        tabB[9];

    function automatic vec_t mk(logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                                logic rw, logic [1:0] rsrc, logic pc, logic rst,
                                logic [7:0] exp);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.rw = rw;
        v.rsrc = rsrc; v.pc = pc; v.rst = rst; v.exp = exp;
        return v;
    endfunction

    task automatic applyVec(input bit sel, input vec_t v, input string name);
        logic [7:0] got, exp;
        @(posedge clk);
        #1;
        if (!sel) begin
            aRs1 = v.rs1; aRs2 = v.rs2; aRd = v.rd; aRw = v.rw;
            aRes = v.rsrc; aPc = v.pc; aRst = v.rst;
        end else begin
            bRs1 = v.rs1; bRs2 = v.rs2; bRd = v.rd; bRw = v.rw;
            bRes = v.rsrc; bPc = v.pc; bRst = v.rst;
        end
        expQ.push_back(v.exp);
        @(negedge clk);
        got = sel ? {bStallF, bStallD, bFlushD, bFlushE, bFwdA, bFwdB}
                  : {aStallF, aStallD, aFlushD, aFlushE, aFwdA, aFwdB};
        exp = expQ.pop_front();
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: outputs {SF,SD,FD,FE,FA,FB} got %b expected %b", name, got, exp);
        end
    endtask

    task automatic checkCnt(input string name, input int unsigned got, input int unsigned exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Forwarding instance: M/W forwarding, load-use, redirect, x0, mid-stall reset.
        tabA[0]  = mk(0, 0, 0,  0, 2'b00, 0, 0, Z);
        tabA[1]  = mk(1, 2, 5,  1, 2'b00, 0, 0, Z);
        tabA[2]  = mk(5, 0, 9,  1, 2'b00, 0, 0, Z);
        tabA[3]  = mk(0, 0, 0,  0, 2'b00, 0, 0, 8'b0000_1000);
        tabA[4]  = mk(0, 0, 0,  0, 2'b00, 0, 0, Z);
        tabA[5]  = mk(1, 2, 5,  1, 2'b00, 0, 0, Z);
        tabA[6]  = mk(0, 0, 0,  0, 2'b00, 0, 0, Z);
        tabA[7]  = mk(3, 5, 10, 1, 2'b00, 0, 0, Z);
        tabA[8]  = mk(0, 0, 0,  0, 2'b00, 0, 0, 8'b0000_0001);
        tabA[9]  = mk(0, 0, 0,  0, 2'b00, 0, 0, Z);
        tabA[10] = mk(1, 2, 5,  1, 2'b00, 0, 0, Z);
        tabA[11] = mk(3, 4, 5,  1, 2'b00, 0, 0, Z);
        tabA[12] = mk(5, 5, 11, 1, 2'b00, 0, 0, Z);
        tabA[13] = mk(0, 0, 0,  0, 2'b00, 0, 0, 8'b0000_1010);
        tabA[14] = mk(0, 0, 0,  0, 2'b00, 0, 0, Z);
        tabA[15] = mk(1, 0, 6,  1, 2'b01, 0, 0, Z);
        tabA[16] = mk(6, 2, 12, 1, 2'b00, 0, 0, ST);
        tabA[17] = mk(6, 2, 12, 1, 2'b00, 0, 0, ST);
        tabA[18] = mk(6, 2, 12, 1, 2'b00, 0, 0, Z);
        tabA[19] = mk(0, 0, 0,  0, 2'b00, 0, 0, Z);
        tabA[20] = mk(1, 0, 6,  1, 2'b01, 0, 0, Z);
        tabA[21] = mk(6, 0, 13, 1, 2'b00, 1, 0, BR);
        tabA[22] = mk(0, 0, 0,  0, 2'b00, 0, 0, Z);
        tabA[23] = mk(1, 2, 0,  1, 2'b01, 0, 0, Z);
        tabA[24] = mk(0, 0, 14, 1, 2'b00, 0, 0, Z);
        tabA[25] = mk(0, 0, 0,  0, 2'b00, 0, 0, Z);
        tabA[26] = mk(1, 0, 6,  1, 2'b01, 0, 0, Z);
        tabA[27] = mk(6, 0, 16, 1, 2'b00, 0, 0, ST);
        tabA[28] = mk(6, 0, 16, 1, 2'b00, 0, 1, ST);
        tabA[29] = mk(6, 0, 16, 1, 2'b00, 0, 0, Z);
        tabA[30] = mk(0, 0, 0,  0, 2'b00, 0, 0, Z);

        // Stall-only instance: E/M producer stalls, W does not, x0 never stalls.
        tabB[0] = mk(0, 0, 0,  0, 2'b00, 0, 0, Z);
        tabB[1] = mk(1, 0, 7,  1, 2'b00, 0, 0, Z);
        tabB[2] = mk(7, 0, 15, 1, 2'b00, 0, 0, ST);
        tabB[3] = mk(7, 0, 15, 1, 2'b00, 0, 0, ST);
        tabB[4] = mk(7, 0, 15, 1, 2'b00, 0, 0, Z);
        tabB[5] = mk(0, 0, 0,  0, 2'b00, 0, 0, Z);
        tabB[6] = mk(1, 0, 0,  1, 2'b00, 0, 0, Z);
        tabB[7] = mk(0, 0, 17, 1, 2'b00, 0, 0, Z);
        tabB[8] = mk(0, 0, 0,  0, 2'b00, 0, 0, Z);

        aRst = 1'b1; bRst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        aRst = 1'b0; bRst = 1'b0;

        for (int i = 0; i < 31; i++) begin
            applyVec(1'b0, tabA[i], $sformatf("A[%0d]", i));
            if (i == 0) begin
                checkCnt("A reset StallCnt", aStallCnt, 0);
                checkCnt("A reset FlushCnt", aFlushCnt, 0);
            end
            if (i == 18) checkCnt("A load-use StallCnt", aStallCnt, 2);
            if (i == 22) begin
                checkCnt("A redirect FlushCnt", aFlushCnt, 1);
                checkCnt("A redirect StallCnt", aStallCnt, 2);
            end
            if (i == 28) checkCnt("A pre-reset StallCnt", aStallCnt, 3);
            if (i == 29) begin
                checkCnt("A post-reset StallCnt", aStallCnt, 0);
                checkCnt("A post-reset FlushCnt", aFlushCnt, 0);
            end
        end

        for (int i = 0; i < 9; i++) begin
            applyVec(1'b1, tabB[i], $sformatf("B[%0d]", i));
            if (i == 0) checkCnt("B reset StallCnt", bStallCnt, 0);
            if (i == 4) checkCnt("B raw StallCnt", bStallCnt, 2);
        end

        // Seven back-to-back producer/consumer pairs: two stalls each.
        for (int p = 0; p < 7; p++) begin
            applyVec(1'b1, mk(1, 0, 7,  1, 2'b00, 0, 0, Z),  $sformatf("B pair%0d addi", p));
            applyVec(1'b1, mk(7, 0, 15, 1, 2'b00, 0, 0, ST), $sformatf("B pair%0d st1", p));
            applyVec(1'b1, mk(7, 0, 15, 1, 2'b00, 0, 0, ST), $sformatf("B pair%0d st2", p));
            applyVec(1'b1, mk(7, 0, 15, 1, 2'b00, 0, 0, Z),  $sformatf("B pair%0d go", p));
        end
        checkCnt("B StallCnt after 16", bStallCnt, 0);

        // Producer one slot ahead: only the M match stalls, giving the 17th stall.
        applyVec(1'b1, mk(1, 0, 7,  1, 2'b00, 0, 0, Z),  "B gap addi");
        applyVec(1'b1, mk(0, 0, 0,  0, 2'b00, 0, 0, Z),  "B gap nop");
        applyVec(1'b1, mk(0, 7, 18, 1, 2'b00, 0, 0, ST), "B gap st");
        applyVec(1'b1, mk(0, 7, 18, 1, 2'b00, 0, 0, Z),  "B gap go");
        checkCnt("B StallCnt wrap", bStallCnt, 1);
        checkCnt("B FlushCnt", bFlushCnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pl_hazard_unit.md
PL_HAZARD_UNIT -- requirements
Module: pl_hazard_unit

Interface
REQ-001 The block SHALL have parameter FWD_EN, default 1, meaning 1 = forwarding with load-use stall and 0 = stall-only until writeback.
REQ-002 The block SHALL have parameter LOAD_LAT, default 1, legal range 1..3, meaning load-use bubble count.
REQ-003 The block SHALL have parameter CNT_W, default 32, meaning the width of each performance counter.
REQ-004 Port clk, input, 1, meaning the single clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1, meaning synchronous active-high reset.
REQ-006 Ports Rs1D / Rs2D / RdD, input, 5 each, meaning the decode-stage register fields.
REQ-007 Port RegWriteD, input, 1, meaning the decode instruction writes Rd.
REQ-008 Port ResultSrcD, input, 2, meaning the decode result source; 2'b01 marks a load.
REQ-009 Port PCSrcE, input, 1, meaning a taken branch, jump or jalr redirect resolved in Execute.
REQ-010 Ports StallF / StallD, output, 1 each, meaning hold the PC register / hold the F|D register (register enable = ~Stall).
REQ-011 Ports FlushD / FlushE, output, 1 each, meaning clear the F|D / D|E register to a bubble.
REQ-012 Ports ForwardAE / ForwardBE, output, 2 each, meaning the SrcA / SrcB select: 00 register file, 01 W result, 10 M ALU result.
REQ-013 Ports StallCnt / FlushCnt, output, CNT_W each, meaning the cycles with StallD=1 / the cycles with PCSrcE=1.

Function
REQ-014 The block SHALL keep an internal scoreboard of E, M and W entries {Rs1, Rs2, Rd, RegWrite, IsLoad}.
REQ-015 Each cycle the scoreboard SHALL shift E<=D fields, M<=E, W<=M; when FlushE=1 the E entry SHALL load a bubble (all fields zero).
REQ-016 ForwardAE SHALL be 10 if M.RegWrite && M.Rd!=0 && M.Rd==E.Rs1, else 01 if the same test matches W, else 00; ForwardBE SHALL use the same rule on E.Rs2.
REQ-017 When FWD_EN=0, ForwardAE and ForwardBE SHALL be held at 00.
REQ-018 A source of D SHALL "match" an entry when the entry has RegWrite=1, Rd!=0 and Rd equals Rs1D or Rs2D.
REQ-019 When FWD_EN=1, a load-use hazard SHALL exist when the E entry matches and has IsLoad=1; when it exists with the stall counter at 0, the counter SHALL load LOAD_LAT-1 and the block SHALL stall.
REQ-020 While the stall counter is non-zero the block SHALL stall and decrement the counter by 1 per cycle, giving exactly LOAD_LAT stall cycles per load-use hazard.
REQ-021 When FWD_EN=0, the block SHALL stall while the E or M entry matches; a W match SHALL NOT stall, because the register file is write-through.
REQ-022 A stall cycle SHALL assert StallF=1, StallD=1 and FlushE=1.
REQ-023 PCSrcE=1 SHALL assert FlushD=1 and FlushE=1, force StallF=0 and StallD=0, and clear the stall counter, overriding any stall in the same cycle.
REQ-024 All outputs SHALL be combinational from the registered state plus the D inputs (zero latency).
REQ-025 StallCnt SHALL increment by 1 in every cycle where StallD=1, and FlushCnt in every cycle where PCSrcE=1, both wrapping modulo 2^CNT_W.
REQ-026 Register x0 SHALL never cause a stall or a forward.

Reset
REQ-027 While reset=1 at a rising edge, all scoreboard entries SHALL become bubbles, the stall counter 0, and StallCnt and FlushCnt 0.
REQ-028 In the cycle after reset, StallF, StallD, FlushD and FlushE SHALL be 0 and ForwardAE and ForwardBE SHALL be 00 unless the D inputs themselves create a hazard.
REQ-029 A reset asserted mid-stall SHALL abort the stall, with no residual bubble after reset is released.

Structure
REQ-030 Package pl_pkg SHALL hold REG_ADDR_W=5, the FWD_RF/FWD_W/FWD_M encodings, RES_LOAD=2'b01 and the scoreboard entry struct.
REQ-031 The design SHALL have one sub-module, hz_scoreboard: a 3-entry shift register with bubble insertion; hazard, forwarding and counter logic SHALL sit in the top level.

Verification
REQ-032 The bench SHALL cover: add x5 in M, E.Rs1=5 -> ForwardAE=10; same x5 now in W with nothing in M -> ForwardAE=01.
REQ-033 The bench SHALL cover: lw x6 in E, D uses x6, LOAD_LAT=2 -> StallF/StallD/FlushE high for exactly 2 cycles, StallCnt=2.
REQ-034 The bench SHALL cover: a load-use stall with PCSrcE=1 in the same cycle -> StallD=0, FlushD=1, FlushE=1, counter cleared, FlushCnt=1.
REQ-035 The bench SHALL cover: FWD_EN=0 with addi x7 followed immediately by a reader of x7 -> 2 stall cycles, Forward*=00 throughout.
REQ-036 The bench SHALL cover: a writer to x0 followed by a reader of x0 -> no stall, Forward*=00.
REQ-037 The bench SHALL cover: reset asserted during the second stall cycle -> the next cycle has all outputs 0 and both counters 0; CNT_W=4 with 17 stalls -> StallCnt=1.
